operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports: clk input 1 clock, all state on rising edge; rst_n input 1 asynchronous active-low reset.
REQ-002 SHALL have inValid input 1 (decoded op offered), inReady output 1 (op accepted when inValid && inReady), inRs1Adrs/inRs2Adrs/inRdAdrs input 5 each, inTag input 8 (opaque op id).
REQ-003 SHALL have rs1Adrs/rs2Adrs output 5 each to the register-file read ports, and rs1Data/rs2Data input 32 each, valid one clock after the address is sampled.
REQ-004 SHALL have wbEnable input 1, wbRdAdrs input 5, wbRdData input 32: the same write-port signals the register file receives, snooped for bypass.
REQ-005 SHALL have outValid output 1, outReady input 1, outRs1Data/outRs2Data output 32, outRdAdrs output 5, outTag output 8.

Function
REQ-006 SHALL implement two registered stages: F (read in flight: fVld, fRs1, fRs2, fRd, fTag) and O (output holding register).
REQ-007 SHALL compute advF = fVld && (!outValid || outReady) and inReady = !fVld || advF, so that one op per clock sustains when outReady stays high.
REQ-008 SHALL drive rs1Adrs/rs2Adrs = inRs1Adrs/inRs2Adrs in an accept cycle, else fRs1/fRs2, so a stalled F re-reads its addresses every clock.
REQ-009 SHALL register the previous-edge write (pEn = wbEnable && wbRdAdrs != 0, pAdrs, pData) each clock.
REQ-010 SHALL form each F operand as: 0 if its address is 0; else pData if pEn && pAdrs == address; else rsXData from the register file.
REQ-011 SHALL transfer F into O on advF: outRs1Data, outRs2Data, outRdAdrs, outTag loaded and outValid set; without a new accept, fVld clears on the same edge.
REQ-012 SHALL clear outValid when outValid && outReady && !advF; O contents SHALL NOT change while outValid && !outReady, except as in REQ-019.
REQ-013 SHALL accept a new op into F on the same edge that F transfers to O (back-to-back, zero bubbles).
REQ-014 SHALL give accept-to-outValid latency of 2 clocks with no stall; a write on the accept edge or on any stall edge SHALL be reflected via REQ-010.
REQ-015 SHALL never emit nonzero data for address 0, regardless of register-file contents or wbEnable with wbRdAdrs = 0.
REQ-016 SHALL keep outValid asserted and O stable until outReady; inValid dropping after acceptance SHALL NOT affect the op in flight.

Reset
REQ-017 SHALL, while rst_n is low, asynchronously force fVld = 0, outValid = 0, pEn = 0, fRs1/fRs2/fRd/pAdrs = 0, fTag = 0, outRs1Data/outRs2Data/pData = 0, outRdAdrs = 0, outTag = 0; inReady reads 1 after reset.
REQ-018 SHALL discard any op in F or O when reset asserts mid-operation; the first op after deassertion SHALL behave as from idle.

Configuration
REQ-019 SHALL, with OPFETCH_HOLD_SNOOP_EN defined, update outRsXData with wbRdData on any edge where outValid && !outReady && wbEnable && wbRdAdrs != 0 && wbRdAdrs matches that operand's captured address; O SHALL then also hold both source addresses.
REQ-020 SHALL, without OPFETCH_HOLD_SNOOP_EN, freeze O operands at transfer, omit the held source addresses, and leave all other behaviour unchanged.

Verification
REQ-021 SHALL cover: x5 = 0x11, accept rs1 = 5, rs2 = 0, outReady = 1 -> outValid 2 clocks later with outRs1Data = 0x11, outRs2Data = 0.
REQ-022 SHALL cover: wbEnable, wbRdAdrs = 7, wbRdData = 0xAB on the accept edge of rs1 = 7 -> outRs1Data = 0xAB, not the stale value.
REQ-023 SHALL cover: outReady = 0 for 3 clocks with two ops offered -> first op held stable in O, second op held in F, inReady = 0; outReady = 1 -> both delivered in order by tag.
REQ-024 SHALL cover: wbEnable, wbRdAdrs = 0, wbRdData = 0xFFFFFFFF with rs1 = 0 -> outRs1Data = 0.
REQ-025 SHALL cover: O stalled holding rs2 = 9, write x9 = 0x55 -> outRs2Data = 0x55 with OPFETCH_HOLD_SNOOP_EN, unchanged without it.
REQ-026 SHALL cover: rst_n low with ops in F and O -> outValid = 0 immediately, inReady = 1, no stale op emitted after release.

Source files
------------

// File: rtl/operand_fetch.sv
// Two-stage operand fetch: F waits on the register-file read, O holds the op for the consumer.
// Define OPFETCH_HOLD_SNOOP_EN to let a stalled O absorb register-file writes to its sources.
module operand_fetch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inValid,
   output logic        inReady,
   input  logic [4:0]  inRs1Adrs,
   input  logic [4:0]  inRs2Adrs,
   input  logic [4:0]  inRdAdrs,
   input  logic [7:0]  inTag,
   output logic [4:0]  rs1Adrs,
   output logic [4:0]  rs2Adrs,
   input  logic [31:0] rs1Data,
   input  logic [31:0] rs2Data,
   input  logic        wbEnable,
   input  logic [4:0]  wbRdAdrs,
   input  logic [31:0] wbRdData,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] outRs1Data,
   output logic [31:0] outRs2Data,
   output logic [4:0]  outRdAdrs,
   output logic [7:0]  outTag
);

   logic        fVld;
   logic [4:0]  fRs1;
   logic [4:0]  fRs2;
   logic [4:0]  fRd;
   logic [7:0]  fTag;
   logic        pEn;
   logic [4:0]  pAdrs;
   logic [31:0] pData;
   logic        advF;
   logic        accept;
   logic [31:0] fOp1;
   logic [31:0] fOp2;

   // The register file returns data for the address sampled on the previous edge, so a write
   // landing on that same edge is missed by the array and must come from the pData bypass.
   function automatic logic [31:0] pickOperand(input logic [4:0] adrs, input logic [31:0] rfData,
                                               input logic bypEn, input logic [4:0] bypAdrs,
                                               input logic [31:0] bypData);
      if (adrs == 5'd0)
         return 32'd0;
      else if (bypEn && bypAdrs == adrs)
         return bypData;
      else
         return rfData;
   endfunction

   assign advF    = fVld && (!outValid || outReady);
   assign inReady = !fVld || advF;
   assign accept  = inValid && inReady;
   assign rs1Adrs = accept ? inRs1Adrs : fRs1;
   assign rs2Adrs = accept ? inRs2Adrs : fRs2;
   assign fOp1    = pickOperand(fRs1, rs1Data, pEn, pAdrs, pData);
   assign fOp2    = pickOperand(fRs2, rs2Data, pEn, pAdrs, pData);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pEn   <= 1'b0;
         pAdrs <= 5'd0;
         pData <= 32'd0;
      end else begin
         pEn   <= wbEnable && (wbRdAdrs != 5'd0);
         pAdrs <= wbRdAdrs;
         pData <= wbRdData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fVld <= 1'b0;
         fRs1 <= 5'd0;
         fRs2 <= 5'd0;
         fRd  <= 5'd0;
         fTag <= 8'd0;
      end else if (accept) begin
         fVld <= 1'b1;
         fRs1 <= inRs1Adrs;
         fRs2 <= inRs2Adrs;
         fRd  <= inRdAdrs;
         fTag <= inTag;
      end else if (advF) begin
         fVld <= 1'b0;
      end
   end

`ifdef OPFETCH_HOLD_SNOOP_EN
   logic [4:0] oRs1;
   logic [4:0] oRs2;
   logic       holdWb;

   assign holdWb = outValid && !outReady && wbEnable && (wbRdAdrs != 5'd0);

   // A stalled O would otherwise go stale once the register file is written behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid   <= 1'b0;
         outRs1Data <= 32'd0;
         outRs2Data <= 32'd0;
         outRdAdrs  <= 5'd0;
         outTag     <= 8'd0;
         oRs1       <= 5'd0;
         oRs2       <= 5'd0;
      end else if (advF) begin
         outValid   <= 1'b1;
         outRs1Data <= fOp1;
         outRs2Data <= fOp2;
         outRdAdrs  <= fRd;
         outTag     <= fTag;
         oRs1       <= fRs1;
         oRs2       <= fRs2;
      end else if (outValid && outReady) begin
         outValid <= 1'b0;
      end else if (holdWb) begin
         if (wbRdAdrs == oRs1)
            outRs1Data <= wbRdData;
         if (wbRdAdrs == oRs2)
            outRs2Data <= wbRdData;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid   <= 1'b0;
         outRs1Data <= 32'd0;
         outRs2Data <= 32'd0;
         outRdAdrs  <= 5'd0;
         outTag     <= 8'd0;
      end else if (advF) begin
         outValid   <= 1'b1;
         outRs1Data <= fOp1;
         outRs2Data <= fOp2;
         outRdAdrs  <= fRd;
         outTag     <= fTag;
      end else if (outValid && outReady) begin
         outValid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a read-old register-file model around the DUT.
module tb_operand_fetch;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [4:0]  inRs1Adrs;
   logic [4:0]  inRs2Adrs;
   logic [4:0]  inRdAdrs;
   logic [7:0]  inTag;
   logic [4:0]  rs1Adrs;
   logic [4:0]  rs2Adrs;
   logic [31:0] rs1Data;
   logic [31:0] rs2Data;
   logic        wbEnable;
   logic [4:0]  wbRdAdrs;
   logic [31:0] wbRdData;
   logic        outValid;
   logic        outReady;
   logic [31:0] outRs1Data;
   logic [31:0] outRs2Data;
   logic [4:0]  outRdAdrs;
   logic [7:0]  outTag;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [7:0]  tag;
   } expT;

   expT expQ[$];
   int  checkCount = 0;
   int  passCount  = 0;

   logic [31:0] rf [32];
   bit          rfInit = 1'b0;

   operand_fetch dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .inRs1Adrs(inRs1Adrs), .inRs2Adrs(inRs2Adrs), .inRdAdrs(inRdAdrs), .inTag(inTag),
      .rs1Adrs(rs1Adrs), .rs2Adrs(rs2Adrs), .rs1Data(rs1Data), .rs2Data(rs2Data),
      .wbEnable(wbEnable), .wbRdAdrs(wbRdAdrs), .wbRdData(wbRdData),
      .outValid(outValid), .outReady(outReady), .outRs1Data(outRs1Data),
      .outRs2Data(outRs2Data), .outRdAdrs(outRdAdrs), .outTag(outTag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: synchronous read returning the pre-write value, x0 deliberately holds garbage
   always @(posedge clk) begin
      if (!rfInit) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
         rf[0]  <= 32'hDEADBEEF;
         rf[5]  <= 32'h11;
         rfInit <= 1'b1;
      end else begin
         rs1Data <= rf[rs1Adrs];
         rs2Data <= rf[rs2Adrs];
         if (wbEnable) rf[wbRdAdrs] <= wbRdData;
      end
   end

   // Monitor: every handshake pops the oldest expected op
   always @(negedge clk) begin
      if (rst_n && outValid && outReady) begin
         checkCount++;
         if (expQ.size() == 0) begin
            $display("[TB] FAIL unexpected output tag=%0d with empty scoreboard", outTag);
         end else begin
            expT e;
            e = expQ.pop_front();
            if (outRs1Data === e.rs1 && outRs2Data === e.rs2 && outRdAdrs === e.rd && outTag === e.tag)
               passCount++;
            else
               $display("[TB] FAIL out got tag=%0d rd=%0d rs1=%h rs2=%h required tag=%0d rd=%0d rs1=%h rs2=%h",
                        outTag, outRdAdrs, outRs1Data, outRs2Data, e.tag, e.rd, e.rs1, e.rs2);
         end
      end
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checkCount++;
      if (actual === required)
         passCount++;
      else
         $display("[TB] FAIL %s got %h required %h", name, actual, required);
   endtask

   // Offers one op, waits (bounded) for acceptance and records its expected result
   task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic [7:0] tag, input logic [31:0] e1, input logic [31:0] e2);
      int n;
      expT e;
      inValid   = 1'b1;
      inRs1Adrs = r1;
      inRs2Adrs = r2;
      inRdAdrs  = rd;
      inTag     = tag;
      n = 0;
      while (!inReady && n < 50) begin
         waitCycle();
         n++;
      end
      if (!inReady) begin
         checkCount++;
         $display("[TB] FAIL accept timeout tag=%0d inReady got 0 required 1", tag);
      end else begin
         e.rs1 = e1; e.rs2 = e2; e.rd = rd; e.tag = tag;
         expQ.push_back(e);
         waitCycle();
      end
      inValid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; inValid = 1'b0; inRs1Adrs = '0; inRs2Adrs = '0; inRdAdrs = '0; inTag = '0;
      wbEnable = 1'b0; wbRdAdrs = '0; wbRdData = '0; outReady = 1'b1;
      #2;
      checkOutput("resetOutValid", {31'd0, outValid}, 32'd0);
      checkOutput("resetInReady", {31'd0, inReady}, 32'd1);
      #10 rst_n = 1'b1;
      waitCycle();

      // x5 read with x0, two-clock latency
      applyStimulus(5'd5, 5'd0, 5'd3, 8'd1, 32'h11, 32'd0);
      checkOutput("latencyEarly", {31'd0, outValid}, 32'd0);
      waitCycle();
      checkOutput("latencyOnTime", {31'd0, outValid}, 32'd1);
      waitCycle();

      // Write on the accept edge must be bypassed
      wbEnable = 1'b1; wbRdAdrs = 5'd7; wbRdData = 32'hAB;
      applyStimulus(5'd7, 5'd5, 5'd4, 8'd2, 32'hAB, 32'h11);
      wbEnable = 1'b0;
      waitCycle();

      // A write aimed at x0 never reaches an operand
      wbEnable = 1'b1; wbRdAdrs = 5'd0; wbRdData = 32'hFFFFFFFF;
      applyStimulus(5'd0, 5'd7, 5'd6, 8'd3, 32'd0, 32'hAB);
      wbEnable = 1'b0;
      waitCycle();
      waitCycle();

      // Back-pressure: tag 10 held in O, tag 11 held in F while x3 is written
      outReady = 1'b0;
      applyStimulus(5'd1, 5'd2, 5'd8, 8'd10, 32'h1001, 32'h1002);
      applyStimulus(5'd3, 5'd4, 5'd9, 8'd11, 32'h33, 32'h1004);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin
            wbEnable = 1'b1; wbRdAdrs = 5'd3; wbRdData = 32'h33;
         end
         waitCycle();
         wbEnable = 1'b0;
         checkOutput("stallInReady", {31'd0, inReady}, 32'd0);
         checkOutput("stallTag", {24'd0, outTag}, 32'd10);
         checkOutput("stallRs1", outRs1Data, 32'h1001);
      end
      outReady = 1'b1;
      waitCycle();
      waitCycle();
      waitCycle();

      // Write to a source of the op held in O
      outReady = 1'b0;
`ifdef OPFETCH_HOLD_SNOOP_EN
      applyStimulus(5'd8, 5'd9, 5'd10, 8'd20, 32'h1008, 32'h55);
`else
      applyStimulus(5'd8, 5'd9, 5'd10, 8'd20, 32'h1008, 32'h1009);
`endif
      waitCycle();
      wbEnable = 1'b1; wbRdAdrs = 5'd9; wbRdData = 32'h55;
      waitCycle();
      wbEnable = 1'b0;
`ifdef OPFETCH_HOLD_SNOOP_EN
      checkOutput("holdSnoopRs2", outRs2Data, 32'h55);
`else
      checkOutput("holdFrozenRs2", outRs2Data, 32'h1009);
`endif
      outReady = 1'b1;
      waitCycle();
      waitCycle();

      // Reset with ops in both F and O
      outReady = 1'b0;
      applyStimulus(5'd1, 5'd2, 5'd11, 8'd30, 32'h1001, 32'h1002);
      applyStimulus(5'd3, 5'd4, 5'd12, 8'd31, 32'h33, 32'h1004);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midResetOutValid", {31'd0, outValid}, 32'd0);
      checkOutput("midResetInReady", {31'd0, inReady}, 32'd1);
      expQ.delete();
      #3 rst_n = 1'b1;
      waitCycle();
      outReady = 1'b1;
      applyStimulus(5'd5, 5'd9, 5'd13, 8'd32, 32'h11, 32'h55);
      for (int i = 0; i < 4; i++) waitCycle();
      checkOutput("drain", expQ.size(), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
